psum_acc_buf: RTL

- Downstream consumer of the per-PE psum adder chain.
- Accumulates a stream of signed DWIDTH partial sums over cfg_npass input-channel passes into a local buffer of up to DEPTH output pixels.
- On the final pass it adds bias, applies optional ReLU, a rounding arithmetic right shift and signed saturation.
- Emits OWIDTH results over a valid/ready interface toward the output writer.

---
 rtl/psum_acc_buf.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/psum_acc_buf.sv
// Partial-sum accumulation buffer: sums cfg_npass passes of psums per output pixel,
// then adds bias, applies optional ReLU, a rounding shift and saturation on the last pass.
module psum_acc_buf #(
    parameter int DWIDTH = 32,
    parameter int OWIDTH = 16,
    parameter int DEPTH  = 16,
    parameter int AWIDTH = 4,
    parameter int PWIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     cfg_start,
    input  logic [PWIDTH-1:0]        cfg_npass,
    input  logic [AWIDTH:0]          cfg_len,
    input  logic [4:0]               cfg_shift,
    input  logic                     cfg_relu,
    input  logic signed [DWIDTH-1:0] bias,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DWIDTH-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OWIDTH-1:0] out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {IDLE, ACC, FLUSH} state_t;

    localparam logic signed [DWIDTH+1:0] SAT_MAX = {{(DWIDTH+3-OWIDTH){1'b0}}, {(OWIDTH-1){1'b1}}};
    localparam logic signed [DWIDTH+1:0] SAT_MIN = ~SAT_MAX;
    localparam logic signed [DWIDTH+1:0] ONE     = {{(DWIDTH+1){1'b0}}, 1'b1};

    state_t state, state_nxt;

    logic [PWIDTH-1:0]        npass_r, pass;
    logic [AWIDTH:0]          len_r;
    logic [4:0]               shift_r;
    logic                     relu_r;
    logic signed [DWIDTH-1:0] bias_r;
    logic [AWIDTH-1:0]        addr;
    logic signed [DWIDTH-1:0] mem [DEPTH];

    logic                     last_pass, addr_end, accept, fin_beat, out_take, start_empty;
    logic signed [DWIDTH-1:0] sum;
    logic signed [DWIDTH+1:0] xe, xr, rnd;
    logic signed [OWIDTH-1:0] sat;

    assign last_pass   = (pass == npass_r - PWIDTH'(1));
    assign addr_end    = ({1'b0, addr} == len_r - (AWIDTH+1)'(1));
    assign out_take    = out_valid && out_ready;
    // On the final pass a beat is only taken if the output register can make room for it.
    assign in_ready    = (state == ACC) && (!last_pass || !out_valid || out_ready);
    assign accept      = in_valid && in_ready;
    assign fin_beat    = accept && last_pass;
    assign start_empty = (cfg_npass == '0) || (cfg_len == '0);
    assign busy        = (state != IDLE);

    assign sum = (pass == '0) ? in_data : mem[addr] + in_data;

    // Two guard bits: one for sum+bias, one so adding the rounding constant cannot overflow.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        xe  = {{2{sum[DWIDTH-1]}}, sum} + {{2{bias_r[DWIDTH-1]}}, bias_r};
        rnd = '0;
        if (relu_r && xe[DWIDTH+1])
            xe = '0;
        if (shift_r != 5'd0)
            rnd = ONE << (shift_r - 5'd1);
        xr = (xe + rnd) >>> shift_r;
        if (xr > SAT_MAX)
            sat = SAT_MAX[OWIDTH-1:0];
        else if (xr < SAT_MIN)
            sat = SAT_MIN[OWIDTH-1:0];
        else
            sat = xr[OWIDTH-1:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cfg_start && !start_empty) state_nxt = ACC;
            ACC:     if (fin_beat && addr_end)      state_nxt = FLUSH;
            FLUSH:   if (out_take)                  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            addr      <= '0;
            pass      <= '0;
            npass_r   <= '0;
            len_r     <= '0;
            shift_r   <= '0;
            relu_r    <= 1'b0;
            bias_r    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            if (state == IDLE && cfg_start) begin
                npass_r <= cfg_npass;
                len_r   <= cfg_len;
                shift_r <= cfg_shift;
                relu_r  <= cfg_relu;
                bias_r  <= bias;
                addr    <= '0;
                pass    <= '0;
                done    <= start_empty;
            end
            if (accept) begin
                if (addr_end) begin
                    addr <= '0;
                    pass <= pass + PWIDTH'(1);
                end else begin
                    addr <= addr + AWIDTH'(1);
                end
            end
            if (fin_beat) begin
                out_valid <= 1'b1;
                out_data  <= sat;
                out_last  <= addr_end;
            end else if (out_take) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (state == FLUSH && out_take)
                done <= 1'b1;
        end
    end

    // NOTE: the buffer has no reset; pass 0 always overwrites an entry before it is read.
    always_ff @(posedge clk) begin
        if (accept && !last_pass)
            mem[addr] <= sum;
    end

endmodule
